if_id_buffer: RTL and testbench
===============================

# if_id_buffer

Per-thread instruction queue between the fetch stage (`if_stage`) and decode/dispatch in the 2-way superscalar SMT core. It absorbs one fetched instruction per thread per cycle and presents up to two instructions per cycle to decode, oldest first. It raises per-thread full flags that the top level ORs into the fetch stall inputs, and it flushes a thread's queue on that thread's taken branch.

## Interface
- DEPTH, 8, entries per thread queue; power of two, ≥2
- clock  in  1  system clock
- reset  in  1  synchronous, active-high; clears both queues
- is_two_threads  in  1  SMT mode; only changes while `reset`=1
- thread1_inst_in / thread2_inst_in  in  32  fetched instruction (from `threadN_inst_out`)
- thread1_inst_valid / thread2_inst_valid  in  1  push request
- thread1_pc_in / thread2_pc_in  in  64  PC of the pushed instruction
- thread1_branch_is_taken / thread2_branch_is_taken  in  1  flush that thread's queue
- dispatch_stall  in  1  global stall: RS full or RAT stall; blocks both slots
- thread1_dispatch_stall / thread2_dispatch_stall  in  1  per-thread stall: ROB1/ROB2 full
- thread1_buffer_full / thread2_buffer_full  out  1  queue count == DEPTH
- inst_out_0 / inst_out_1  out  32  slot instruction; slot0 is older when both slots hold the same thread
- pc_out_0 / pc_out_1  out  64  slot PC
- thread_id_0 / thread_id_1  out  1  0 = thread1, 1 = thread2
- valid_0 / valid_1  out  1  slot holds a dispatchable instruction

## Operation
- Each thread has a circular queue with head pointer, tail pointer and count. The count is `$clog2(DEPTH)+1` bits wide. Pointers wrap modulo DEPTH.
- Push: `threadN_inst_valid` && !full && !`threadN_branch_is_taken` writes at tail. A push while full is dropped; fetch must gate on `threadN_buffer_full`. When `is_two_threads`=0, thread2 inputs are ignored and the thread2 queue stays empty.
- Slot fill, single-thread mode: slot0 = thread1 head, slot1 = thread1 head+1. `valid_1` requires count ≥ 2.
- Slot fill, two-thread mode: slot0 = thread1 head, slot1 = thread2 head.
- Validity: `valid_k` = entry present && !`dispatch_stall` && !stall of that slot's thread && !`branch_is_taken` of that thread.
- Pop: every slot with `valid_k`=1 is consumed at the clock edge. Decode has no ready signal; a valid slot is accepted.
- Count update: count_next = count + push − pops, with pops ∈ {0,1,2}. Push and pop in the same cycle on a full queue: the push is dropped, because full is evaluated on the pre-pop count.
- Flush: `threadN_branch_is_taken` sets that queue's head, tail and count to 0 at the edge. It overrides a same-cycle push and pop of that thread. The other thread is unaffected.
- Reset: both queues empty. All outputs read 0: `valid_*`=0, `inst_out_*`=0, `pc_out_*`=0, `thread_id_*`=0, full flags = 0.
- When a slot is invalid, its `inst_out`, `pc_out` and `thread_id` are driven to 0.

## Timing
- Full flags are combinational from the registered count, so fetch sees them in the same cycle.
- Without bypass, a pushed instruction appears on a slot the cycle after the push edge (1-cycle latency).
- Valid outputs are combinational from the registered state and the current stall/flush inputs.
- Simultaneous events: a flush of one thread does not affect push/pop of the other. A global stall with a push just grows the count.
- Reset mid-operation: all contents are lost at the first reset edge, regardless of stalls or flushes.

## Configuration
- `IF_ID_BUFFER_BYPASS_EN` defined: an incoming push that would become the next slot-visible entry drives the slot combinationally in the same cycle (0-cycle latency). This covers an empty queue, and count==1 for slot1 in single-thread mode.
  - If that slot pops in the same cycle, the instruction is not written to the queue.
  - Bypass is suppressed during that thread's flush and when the queue is full.
- Not defined: no combinational path from `threadN_inst_in` to any output; latency is exactly 1 cycle.

## Structure
- Shared package (`if_id_pkg`):
  - `IF_ID_DEPTH` default constant
  - `THREAD_ID` enum {THREAD1, THREAD2}
  - `FETCH_ENTRY` struct {inst[31:0], pc[63:0]}
- Sub-module `inst_fifo`, instantiated once per thread:
  - one push port, two read ports (head, head+1), pop count 0–2, flush, full/count outputs
- Top level: slot muxing, stall/flush gating, bypass logic.

## Test plan
- Single-thread streaming: push 0x12539787, 0x01005601, 0x10939707 on thread1 with no stalls → each appears on slot0 with `valid_0`=1 one cycle after its push, in order, with the correct PC.
- Dual-issue drain: single-thread mode, push 3 entries with `dispatch_stall`=1, then release → `valid_0`=`valid_1`=1 with head and head+1 in program order; the third entry appears next cycle on slot0.
- Full/backpressure: DEPTH=8, `dispatch_stall`=1, push 9 instructions → `thread1_buffer_full`=1 after the 8th push; the 9th is dropped; count stays 8.
- Flush: queue holds 4 entries; assert `thread1_branch_is_taken` with a push of 0x12129707 → next cycle count=0, `valid_0`=0, and the pushed instruction is never dispatched.
- SMT: `is_two_threads`=1, push 0x35939780 on thread1 and 0x21118801 on thread2; then hold `thread1_dispatch_stall`=1 → slot1 keeps dispatching thread2 while slot0 stays 0 and thread1 fills up.
- Reset mid-operation: both queues non-empty, assert `reset` for one cycle → all outputs 0, full flags 0, and the first post-reset push behaves as in an empty queue.

Source files
------------

// File: rtl/if_id_pkg.sv
// Shared types and defaults for the IF/ID instruction buffer.
package if_id_pkg;

  localparam int IF_ID_DEPTH = 8;

  typedef enum logic {
    THREAD1 = 1'b0,
    THREAD2 = 1'b1
  } THREAD_ID;

  typedef struct packed {
    logic [31:0] inst;
    logic [63:0] pc;
  } FETCH_ENTRY;

endpackage

// File: rtl/if_id_buffer_inst_fifo.sv
// inst_fifo: one thread's circular instruction queue with a single push port,
// two read ports (head, head+1), a 0-2 entry pop and a synchronous flush.
module inst_fifo
  import if_id_pkg::*;
#(
  parameter int DEPTH = IF_ID_DEPTH
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [31:0]              push_inst,
  input  logic [63:0]              push_pc,
  input  logic [1:0]               pop_count,
  output logic [31:0]              head_inst,
  output logic [63:0]              head_pc,
  output logic [31:0]              next_inst,
  output logic [63:0]              next_pc,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  FETCH_ENTRY      mem [DEPTH];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [PW-1:0]   head_plus1;
  logic            wr_en;

  // Full is judged on the pre-pop count, so a push into a full queue is dropped
  // even when a pop frees a slot in the same cycle.
  assign full       = (count == CW'(DEPTH));
  assign wr_en      = push && !full && !flush && !reset;
  assign head_plus1 = head + PW'(1);

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (wr_en)
        tail <= tail + PW'(1);
      head  <= head + PW'(pop_count);
      count <= count + CW'(wr_en) - CW'(pop_count);
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en)
      mem[tail] <= '{inst: push_inst, pc: push_pc};
  end

  assign head_inst = mem[head].inst;
  assign head_pc   = mem[head].pc;
  assign next_inst = mem[head_plus1].inst;
  assign next_pc   = mem[head_plus1].pc;

endmodule

// File: rtl/if_id_buffer.sv
// if_id_buffer: per-thread fetch queues feeding two decode slots, oldest first.
// Optional same-cycle bypass of an incoming push is enabled by IF_ID_BUFFER_BYPASS_EN.
module if_id_buffer
  import if_id_pkg::*;
#(
  parameter int DEPTH = IF_ID_DEPTH
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        is_two_threads,
  input  logic [31:0] thread1_inst_in,
  input  logic [31:0] thread2_inst_in,
  input  logic        thread1_inst_valid,
  input  logic        thread2_inst_valid,
  input  logic [63:0] thread1_pc_in,
  input  logic [63:0] thread2_pc_in,
  input  logic        thread1_branch_is_taken,
  input  logic        thread2_branch_is_taken,
  input  logic        dispatch_stall,
  input  logic        thread1_dispatch_stall,
  input  logic        thread2_dispatch_stall,
  output logic        thread1_buffer_full,
  output logic        thread2_buffer_full,
  output logic [31:0] inst_out_0,
  output logic [31:0] inst_out_1,
  output logic [63:0] pc_out_0,
  output logic [63:0] pc_out_1,
  output logic        thread_id_0,
  output logic        thread_id_1,
  output logic        valid_0,
  output logic        valid_1
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   push_inst [2];
  logic [63:0]   push_pc   [2];
  logic          q_flush   [2];
  logic          q_push    [2];
  logic [1:0]    q_pop     [2];
  logic [31:0]   head_inst [2];
  logic [63:0]   head_pc   [2];
  logic [31:0]   next_inst [2];
  logic [63:0]   next_pc   [2];
  logic [CW-1:0] q_count   [2];
  logic          q_full    [2];
  logic          push_ok   [2];

  logic          byp0;
  logic          byp1;
  logic          present0;
  logic          present1;
  logic          slot1_stall;
  logic          slot1_flush;
  logic [31:0]   slot0_inst;
  logic [63:0]   slot0_pc;
  logic [31:0]   slot1_inst;
  logic [63:0]   slot1_pc;
  THREAD_ID      slot1_tid;

  assign push_inst[0] = thread1_inst_in;
  assign push_inst[1] = thread2_inst_in;
  assign push_pc[0]   = thread1_pc_in;
  assign push_pc[1]   = thread2_pc_in;
  assign q_flush[0]   = thread1_branch_is_taken;
  assign q_flush[1]   = is_two_threads && thread2_branch_is_taken;

  assign push_ok[0] = thread1_inst_valid && !q_full[0] && !thread1_branch_is_taken;
  assign push_ok[1] = is_two_threads && thread2_inst_valid && !q_full[1] && !thread2_branch_is_taken;

  for (genvar t = 0; t < 2; t++) begin : g_fifo
    inst_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .flush     (q_flush[t]),
      .push      (q_push[t]),
      .push_inst (push_inst[t]),
      .push_pc   (push_pc[t]),
      .pop_count (q_pop[t]),
      .head_inst (head_inst[t]),
      .head_pc   (head_pc[t]),
      .next_inst (next_inst[t]),
      .next_pc   (next_pc[t]),
      .count     (q_count[t]),
      .full      (q_full[t])
    );
  end

  // A push bypasses only when it would be the very next entry its slot shows.
`ifdef IF_ID_BUFFER_BYPASS_EN
  assign byp0 = push_ok[0] && (q_count[0] == '0);
  assign byp1 = is_two_threads ? (push_ok[1] && (q_count[1] == '0))
                               : (push_ok[0] && (q_count[0] == CW'(1)));
`else
  assign byp0 = 1'b0;
  assign byp1 = 1'b0;
`endif

  assign present0    = (q_count[0] != '0) || byp0;
  assign present1    = is_two_threads ? ((q_count[1] != '0) || byp1)
                                      : ((q_count[0] >= CW'(2)) || byp1);
  assign slot1_stall = is_two_threads ? thread2_dispatch_stall : thread1_dispatch_stall;
  assign slot1_flush = is_two_threads ? thread2_branch_is_taken : thread1_branch_is_taken;

  assign valid_0 = present0 && !dispatch_stall && !thread1_dispatch_stall && !thread1_branch_is_taken;
  assign valid_1 = present1 && !dispatch_stall && !slot1_stall && !slot1_flush;

  // A dispatched bypass entry is consumed directly and never enters its queue.
  always_comb begin
    q_push[0] = push_ok[0];
    q_push[1] = push_ok[1];
    q_pop[0]  = 2'd0;
    q_pop[1]  = 2'd0;
    if (valid_0) begin
      if (byp0)
        q_push[0] = 1'b0;
      else
        q_pop[0] = 2'd1;
    end
    if (valid_1) begin
      if (is_two_threads) begin
        if (byp1)
          q_push[1] = 1'b0;
        else
          q_pop[1] = 2'd1;
      end else begin
        if (byp1)
          q_push[0] = 1'b0;
        else
          q_pop[0] = q_pop[0] + 2'd1;
      end
    end
  end

  always_comb begin
    slot0_inst = byp0 ? thread1_inst_in : head_inst[0];
    slot0_pc   = byp0 ? thread1_pc_in   : head_pc[0];
    if (is_two_threads) begin
      slot1_inst = byp1 ? thread2_inst_in : head_inst[1];
      slot1_pc   = byp1 ? thread2_pc_in   : head_pc[1];
      slot1_tid  = THREAD2;
    end else begin
      slot1_inst = byp1 ? thread1_inst_in : next_inst[0];
      slot1_pc   = byp1 ? thread1_pc_in   : next_pc[0];
      slot1_tid  = THREAD1;
    end
  end

  assign inst_out_0  = valid_0 ? slot0_inst : '0;
  assign pc_out_0    = valid_0 ? slot0_pc   : '0;
  assign thread_id_0 = THREAD1;
  assign inst_out_1  = valid_1 ? slot1_inst : '0;
  assign pc_out_1    = valid_1 ? slot1_pc   : '0;
  assign thread_id_1 = valid_1 ? slot1_tid  : THREAD1;

  assign thread1_buffer_full = q_full[0];
  assign thread2_buffer_full = q_full[1];

endmodule

// File: tb/tb_if_id_buffer.sv
// Scoreboard bench for if_id_buffer (default build, no bypass): stimulus queues
// expected per-thread entries, a negedge monitor checks every dispatched slot.
module tb_if_id_buffer;

  logic        clock = 1'b0;
  logic        reset;
  logic        is_two_threads;
  logic [31:0] thread1_inst_in, thread2_inst_in;
  logic        thread1_inst_valid, thread2_inst_valid;
  logic [63:0] thread1_pc_in, thread2_pc_in;
  logic        thread1_branch_is_taken, thread2_branch_is_taken;
  logic        dispatch_stall, thread1_dispatch_stall, thread2_dispatch_stall;
  logic        thread1_buffer_full, thread2_buffer_full;
  logic [31:0] inst_out_0, inst_out_1;
  logic [63:0] pc_out_0, pc_out_1;
  logic        thread_id_0, thread_id_1;
  logic        valid_0, valid_1;

  typedef struct {
    logic [31:0] inst;
    logic [63:0] pc;
  } exp_t;

  exp_t exp_t1[$];
  exp_t exp_t2[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clock = ~clock;

  if_id_buffer dut (
    .clock                   (clock),
    .reset                   (reset),
    .is_two_threads          (is_two_threads),
    .thread1_inst_in         (thread1_inst_in),
    .thread2_inst_in         (thread2_inst_in),
    .thread1_inst_valid      (thread1_inst_valid),
    .thread2_inst_valid      (thread2_inst_valid),
    .thread1_pc_in           (thread1_pc_in),
    .thread2_pc_in           (thread2_pc_in),
    .thread1_branch_is_taken (thread1_branch_is_taken),
    .thread2_branch_is_taken (thread2_branch_is_taken),
    .dispatch_stall          (dispatch_stall),
    .thread1_dispatch_stall  (thread1_dispatch_stall),
    .thread2_dispatch_stall  (thread2_dispatch_stall),
    .thread1_buffer_full     (thread1_buffer_full),
    .thread2_buffer_full     (thread2_buffer_full),
    .inst_out_0              (inst_out_0),
    .inst_out_1              (inst_out_1),
    .pc_out_0                (pc_out_0),
    .pc_out_1                (pc_out_1),
    .thread_id_0             (thread_id_0),
    .thread_id_1             (thread_id_1),
    .valid_0                 (valid_0),
    .valid_1                 (valid_1)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Sets the push inputs; accepted pushes are queued as expected dispatches.
  task automatic applyStimulus(input logic p1, input logic [31:0] i1, input logic [63:0] pc1, input logic a1,
                               input logic p2, input logic [31:0] i2, input logic [63:0] pc2, input logic a2);
    thread1_inst_valid = p1;
    thread1_inst_in    = i1;
    thread1_pc_in      = pc1;
    thread2_inst_valid = p2;
    thread2_inst_in    = i2;
    thread2_pc_in      = pc2;
    if (p1 && a1) exp_t1.push_back('{inst: i1, pc: pc1});
    if (p2 && a2) exp_t2.push_back('{inst: i2, pc: pc2});
  endtask

  task automatic idle();
    applyStimulus(1'b0, 32'h0, 64'h0, 1'b0, 1'b0, 32'h0, 64'h0, 1'b0);
  endtask

  task automatic checkSlot(input string name, input logic [31:0] inst, input logic [63:0] pc,
                           input logic tid, input logic exp_tid);
    exp_t e;
    checkOutput({name, "_thread_id"}, 64'(tid), 64'(exp_tid));
    checks++;
    if ((exp_tid == 1'b0 && exp_t1.size() == 0) || (exp_tid == 1'b1 && exp_t2.size() == 0)) begin
      errors++;
      $display("[TB] FAIL %s_unexpected: got inst 0x%0h with no entry pending", name, inst);
    end else begin
      e = (exp_tid == 1'b0) ? exp_t1.pop_front() : exp_t2.pop_front();
      checkOutput({name, "_inst"}, 64'(inst), 64'(e.inst));
      checkOutput({name, "_pc"}, pc, e.pc);
    end
  endtask

  // Slot0 is checked before slot1 so single-thread head/head+1 pop in order.
  always @(negedge clock) begin
    if (!reset) begin
      if (valid_0) checkSlot("slot0", inst_out_0, pc_out_0, thread_id_0, 1'b0);
      if (valid_1) checkSlot("slot1", inst_out_1, pc_out_1, thread_id_1, is_two_threads);
    end
  end

  initial begin
    reset = 1'b1;
    is_two_threads = 1'b0;
    thread1_branch_is_taken = 1'b0;
    thread2_branch_is_taken = 1'b0;
    dispatch_stall = 1'b0;
    thread1_dispatch_stall = 1'b0;
    thread2_dispatch_stall = 1'b0;
    idle();
    tick();
    tick();
    reset = 1'b0;
    #1;
    checkOutput("rst_valid0", 64'(valid_0), 64'h0);
    checkOutput("rst_valid1", 64'(valid_1), 64'h0);
    checkOutput("rst_inst0", 64'(inst_out_0), 64'h0);
    checkOutput("rst_pc0", pc_out_0, 64'h0);
    checkOutput("rst_full1", 64'(thread1_buffer_full), 64'h0);
    checkOutput("rst_full2", 64'(thread2_buffer_full), 64'h0);
    tick();

    $display("[TB] single-thread streaming");
    applyStimulus(1'b1, 32'h12539787, 64'h100, 1'b1, 1'b0, 32'h0, 64'h0, 1'b0);
    #1; checkOutput("stream_no_bypass", 64'(valid_0), 64'h0);
    tick();
    applyStimulus(1'b1, 32'h01005601, 64'h104, 1'b1, 1'b0, 32'h0, 64'h0, 1'b0);
    #1; checkOutput("stream_a_valid0", 64'(valid_0), 64'h1);
    checkOutput("stream_a_valid1", 64'(valid_1), 64'h0);
    tick();
    applyStimulus(1'b1, 32'h10939707, 64'h108, 1'b1, 1'b0, 32'h0, 64'h0, 1'b0);
    #1; checkOutput("stream_b_inst0", 64'(inst_out_0), 64'h01005601);
    tick();
    idle();
    #1; checkOutput("stream_c_inst0", 64'(inst_out_0), 64'h10939707);
    tick();
    #1; checkOutput("stream_drained", 64'(valid_0), 64'h0);
    tick();

    $display("[TB] dual-issue drain");
    dispatch_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 32'hA1110001 + 32'(i), 64'h200 + 64'(4 * i), 1'b1, 1'b0, 32'h0, 64'h0, 1'b0);
      #1; checkOutput("dual_stalled_valid0", 64'(valid_0), 64'h0);
      tick();
    end
    idle();
    dispatch_stall = 1'b0;
    #1; checkOutput("dual_valid0", 64'(valid_0), 64'h1);
    checkOutput("dual_valid1", 64'(valid_1), 64'h1);
    checkOutput("dual_inst1", 64'(inst_out_1), 64'hA1110002);
    tick();
    #1; checkOutput("dual_third_inst0", 64'(inst_out_0), 64'hA1110003);
    checkOutput("dual_third_valid1", 64'(valid_1), 64'h0);
    tick();

    $display("[TB] full and backpressure");
    dispatch_stall = 1'b1;
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b1, 32'hD0000000 + 32'(i), 64'h400 + 64'(4 * i), (i < 8), 1'b0, 32'h0, 64'h0, 1'b0);
      #1; checkOutput("full_flag_fill", 64'(thread1_buffer_full), 64'((i == 8) ? 1 : 0));
      tick();
    end
    idle();
    #1; checkOutput("full_flag_hold", 64'(thread1_buffer_full), 64'h1);
    tick();
    dispatch_stall = 1'b0;
    #1; checkOutput("full_drain_valid1", 64'(valid_1), 64'h1);
    tick();
    #1; checkOutput("full_flag_cleared", 64'(thread1_buffer_full), 64'h0);
    tick();
    tick();
    tick();
    #1; checkOutput("full_drained", 64'(valid_0), 64'h0);
    tick();

    $display("[TB] flush");
    dispatch_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 32'hE0000000 + 32'(i), 64'h500 + 64'(4 * i), 1'b1, 1'b0, 32'h0, 64'h0, 1'b0);
      tick();
    end
    dispatch_stall = 1'b0;
    thread1_branch_is_taken = 1'b1;
    exp_t1.delete();
    applyStimulus(1'b1, 32'h12129707, 64'h600, 1'b0, 1'b0, 32'h0, 64'h0, 1'b0);
    #1; checkOutput("flush_valid0", 64'(valid_0), 64'h0);
    tick();
    thread1_branch_is_taken = 1'b0;
    idle();
    #1; checkOutput("flush_empty_valid0", 64'(valid_0), 64'h0);
    tick();
    applyStimulus(1'b1, 32'hF0000001, 64'h700, 1'b1, 1'b0, 32'h0, 64'h0, 1'b0);
    tick();
    idle();
    #1; checkOutput("flush_new_head", 64'(inst_out_0), 64'hF0000001);
    tick();

    $display("[TB] two-thread mode");
    reset = 1'b1;
    is_two_threads = 1'b1;
    tick();
    reset = 1'b0;
    applyStimulus(1'b1, 32'h35939780, 64'h2000, 1'b1, 1'b1, 32'h21118801, 64'h3000, 1'b1);
    tick();
    thread1_dispatch_stall = 1'b1;
    for (int i = 1; i < 8; i++) begin
      applyStimulus(1'b1, 32'h35939780 + 32'(i), 64'h2000 + 64'(4 * i), 1'b1,
                    1'b1, 32'h21118801 + 32'(i), 64'h3000 + 64'(4 * i), 1'b1);
      #1; checkOutput("smt_valid0", 64'(valid_0), 64'h0);
      checkOutput("smt_valid1", 64'(valid_1), 64'h1);
      checkOutput("smt_fill_full1", 64'(thread1_buffer_full), 64'h0);
      tick();
    end
    idle();
    #1; checkOutput("smt_full1", 64'(thread1_buffer_full), 64'h1);
    checkOutput("smt_full2", 64'(thread2_buffer_full), 64'h0);
    checkOutput("smt_inst0_zero", 64'(inst_out_0), 64'h0);
    checkOutput("smt_tid1", 64'(thread_id_1), 64'h1);
    tick();
    thread1_dispatch_stall = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    checkOutput("smt_t1_drained", 64'(exp_t1.size()), 64'h0);

    $display("[TB] reset mid-operation");
    dispatch_stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 32'h66660000 + 32'(i), 64'h4000 + 64'(4 * i), 1'b1,
                    1'b1, 32'h55550000 + 32'(i), 64'h4800 + 64'(4 * i), 1'b1);
      tick();
    end
    idle();
    reset = 1'b1;
    tick();
    exp_t1.delete();
    exp_t2.delete();
    reset = 1'b0;
    dispatch_stall = 1'b0;
    #1; checkOutput("mid_rst_valid0", 64'(valid_0), 64'h0);
    checkOutput("mid_rst_valid1", 64'(valid_1), 64'h0);
    checkOutput("mid_rst_inst1", 64'(inst_out_1), 64'h0);
    checkOutput("mid_rst_pc1", pc_out_1, 64'h0);
    checkOutput("mid_rst_tid1", 64'(thread_id_1), 64'h0);
    tick();
    applyStimulus(1'b1, 32'h77770001, 64'h5000, 1'b1, 1'b0, 32'h0, 64'h0, 1'b0);
    #1; checkOutput("post_rst_latency", 64'(valid_0), 64'h0);
    tick();
    idle();
    #1; checkOutput("post_rst_inst0", 64'(inst_out_0), 64'h77770001);
    tick();
    tick();

    checkOutput("final_pending", 64'(exp_t1.size() + exp_t2.size()), 64'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
